// File: rtl/lib_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lib_arbiter_pkg
// Shared definitions for the pixel-level arbiter:
//   - pixel_lvl_state_t : arbiter FSM states (IDLE, ROW_SEL, COL_GRANT, RELEASE)
//   - LVL_ROWS_DEFAULT / LVL_COLS_DEFAULT : default request array geometry
// ---------------------------------------------------------------------------
package lib_arbiter_pkg;

    localparam int LVL_ROWS_DEFAULT = 4;
    localparam int LVL_COLS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ROW_SEL   = 2'd1,
        COL_GRANT = 2'd2,
        RELEASE   = 2'd3
    } pixel_lvl_state_t;

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker: returns the first set bit of req at or
// after index start, wrapping past the top, plus a found flag.
//   req   : candidate bits
//   start : first index to examine
//   found : at least one bit of req is set
//   idx   : index of the chosen bit (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        int pos;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = int'(start) + i;
            if (pos >= WIDTH) begin
                pos = pos - WIDTH;
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pixel_level_arb.sv
// ---------------------------------------------------------------------------
// pixel_level_arb
// Row-first, then column, round-robin arbiter over a Lvl_ROWS x Lvl_COLS
// request array. One grant at a time under a valid/ack handshake; a one-cycle
// grp_release_o pulse marks a fully served group.
//
// Ports:
//   clk_i         : sole clock, rising edge
//   reset_i       : synchronous active-high reset
//   enable_i      : level enable from the higher level
//   req_i         : request array [row][col]
//   ack_i         : consumer accepts the presented grant
//   gnt_o         : one-hot grant, zero when gnt_valid_o is low
//   gnt_valid_o   : a grant is presented
//   x_add_o       : granted row index
//   y_add_o       : granted column index
//   active_o      : FSM is out of IDLE
//   req_o         : |req_i (combinational)
//   grp_release_o : one-cycle pulse, current group fully served
//
// Build option: PIXEL_LVL_SNAPSHOT_EN
//   defined   : group = req_i captured when leaving IDLE; late requests wait
//   undefined : group = live req_i; late requests join the current group
// ---------------------------------------------------------------------------
module pixel_level_arb
    import lib_arbiter_pkg::*;
#(
    parameter int Lvl_ROWS    = LVL_ROWS_DEFAULT,
    parameter int Lvl_COLS    = LVL_COLS_DEFAULT,
    parameter int Lvl_ROW_ADD = $clog2(Lvl_ROWS),
    parameter int Lvl_COL_ADD = $clog2(Lvl_COLS)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  req_i,
    input  logic                               ack_i,
    output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  gnt_o,
    output logic                               gnt_valid_o,
    output logic [Lvl_ROW_ADD-1:0]             x_add_o,
    output logic [Lvl_COL_ADD-1:0]             y_add_o,
    output logic                               active_o,
    output logic                               req_o,
    output logic                               grp_release_o
);

    pixel_lvl_state_t                  state_q;
    logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] served_q;
    logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] group_req;
    logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] pending;
    logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] gnt_next;
    logic [Lvl_ROW_ADD-1:0]            row_ptr_q;
    logic [Lvl_ROW_ADD-1:0]            row_start;
    logic [Lvl_ROW_ADD-1:0]            row_idx;
    logic [Lvl_ROW_ADD-1:0]            gnt_row;
    logic [Lvl_ROWS-1:0]               row_pending;
    logic                              row_found;
    logic [Lvl_COLS-1:0]               col_req;
    logic [Lvl_COL_ADD-1:0]            col_idx;
    logic                              col_found;
    logic                              advance;

    assign req_o = |req_i;

`ifdef PIXEL_LVL_SNAPSHOT_EN
    logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] snap_q;

    // Sampled on every IDLE cycle, so it holds req_i as seen on the exit edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            snap_q <= '0;
        end else if (state_q == IDLE) begin
            snap_q <= req_i;
        end
    end

    assign group_req = snap_q;
`else
    assign group_req = req_i;
`endif

    assign pending = group_req & ~served_q;

    for (genvar r = 0; r < Lvl_ROWS; r++) begin : g_row_pending
        assign row_pending[r] = |pending[r];
    end

    // Search starts one past the last served row, wrapping to 0.
    assign row_start = (row_ptr_q == Lvl_ROW_ADD'(Lvl_ROWS - 1)) ? '0
                                                                 : row_ptr_q + Lvl_ROW_ADD'(1);

    rr_picker #(
        .WIDTH (Lvl_ROWS),
        .IDX_W (Lvl_ROW_ADD)
    ) u_row_picker (
        .req   (row_pending),
        .start (row_start),
        .found (row_found),
        .idx   (row_idx)
    );

    // ROW_SEL looks at the freshly picked row; COL_GRANT looks for the next
    // column in the granted row, masking the one being handed over now.
    assign gnt_row = (state_q == ROW_SEL) ? row_idx : x_add_o;

    always_comb begin
        col_req = pending[gnt_row];
        if (state_q == COL_GRANT) begin
            col_req[y_add_o] = 1'b0;
        end
    end

    rr_picker #(
        .WIDTH (Lvl_COLS),
        .IDX_W (Lvl_COL_ADD)
    ) u_col_picker (
        .req   (col_req),
        .start ('0),
        .found (col_found),
        .idx   (col_idx)
    );

    always_comb begin
        gnt_next                   = '0;
        gnt_next[gnt_row][col_idx] = 1'b1;
    end

    // A grant whose request vanished (live group only) is retired as if acked.
    assign advance = (state_q == COL_GRANT) &&
                     (ack_i || !pending[x_add_o][y_add_o]);

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        // NOTE: the served mask is a plain register, not a RAM, so it is reset
        // with everything else; a stale mask would hide requests after reset.
        if (reset_i) begin
            state_q       <= IDLE;
            served_q      <= '0;
            row_ptr_q     <= Lvl_ROW_ADD'(Lvl_ROWS - 1);
            gnt_o         <= '0;
            gnt_valid_o   <= 1'b0;
            x_add_o       <= '0;
            y_add_o       <= '0;
            active_o      <= 1'b0;
            grp_release_o <= 1'b0;
        end else begin
            grp_release_o <= 1'b0;
            if (state_q != IDLE && !enable_i) begin
                // Abort: the group is abandoned without a release pulse. An ack
                // taken on this edge still completes its transfer; the served
                // mask is discarded along with the group. Row pointer is kept.
                state_q     <= IDLE;
                active_o    <= 1'b0;
                gnt_o       <= '0;
                gnt_valid_o <= 1'b0;
                served_q    <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (enable_i && req_o) begin
                            state_q  <= ROW_SEL;
                            active_o <= 1'b1;
                        end
                    end
                    ROW_SEL: begin
                        if (row_found) begin
                            state_q     <= COL_GRANT;
                            row_ptr_q   <= row_idx;
                            x_add_o     <= row_idx;
                            y_add_o     <= col_idx;
                            gnt_o       <= gnt_next;
                            gnt_valid_o <= 1'b1;
                        end else begin
                            state_q       <= RELEASE;
                            grp_release_o <= 1'b1;
                        end
                    end
                    COL_GRANT: begin
                        if (advance) begin
                            served_q[x_add_o][y_add_o] <= 1'b1;
                            if (col_found) begin
                                y_add_o <= col_idx;
                                gnt_o   <= gnt_next;
                            end else begin
                                state_q     <= ROW_SEL;
                                gnt_o       <= '0;
                                gnt_valid_o <= 1'b0;
                            end
                        end
                    end
                    RELEASE: begin
                        state_q  <= IDLE;
                        active_o <= 1'b0;
                        served_q <= '0;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_level_arb.sv
// ---------------------------------------------------------------------------
// tb_pixel_level_arb
// Directed bench for pixel_level_arb (4 rows x 2 columns). A behavioural
// model written from the arbitration rules predicts the outputs every cycle;
// hand-computed grant/release cycle numbers pin each scenario.
// ---------------------------------------------------------------------------
module tb_pixel_level_arb;

    localparam int R = 4;
    localparam int C = 2;
`ifdef PIXEL_LVL_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic                clk;
    logic                reset_i;
    logic                enable_i;
    logic                ack_i;
    logic [R-1:0][C-1:0] req_i;
    logic [R-1:0][C-1:0] gnt_o;
    logic                gnt_valid_o;
    logic [1:0]          x_add_o;
    logic [0:0]          y_add_o;
    logic                active_o;
    logic                req_o;
    logic                grp_release_o;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int gx[$];
    int gy[$];
    int gc[$];
    int rc[$];

    pixel_level_arb #(
        .Lvl_ROWS    (R),
        .Lvl_COLS    (C),
        .Lvl_ROW_ADD (2),
        .Lvl_COL_ADD (1)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .req_i         (req_i),
        .ack_i         (ack_i),
        .gnt_o         (gnt_o),
        .gnt_valid_o   (gnt_valid_o),
        .x_add_o       (x_add_o),
        .y_add_o       (y_add_o),
        .active_o      (active_o),
        .req_o         (req_o),
        .grp_release_o (grp_release_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {PH_IDLE, PH_PICK, PH_SHOW, PH_DONE} phase_e;
    phase_e ph    = PH_IDLE;
    bit     srv[R][C];
    bit     grp[R][C];
    int     m_ptr = R - 1;
    int     m_x   = 0;
    int     m_y   = 0;

    function automatic bit m_pend(input int r, input int c);
        bit member;
        member = SNAP ? grp[r][c] : req_i[r][c];
        return member && !srv[r][c];
    endfunction

    function automatic int low_col(input int r);
        for (int c = 0; c < C; c++) begin
            if (m_pend(r, c)) return c;
        end
        return -1;
    endfunction

    task automatic clear_srv();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                srv[r][c] = 1'b0;
    endtask

    always @(posedge clk) begin
        int sel;
        int rr;
        sel = -1;
        rr  = 0;
        if (reset_i) begin
            ph    = PH_IDLE;
            m_ptr = R - 1;
            m_x   = 0;
            m_y   = 0;
            clear_srv();
        end else begin
            case (ph)
                PH_IDLE: begin
                    if (enable_i && req_i != '0) begin
                        for (int r = 0; r < R; r++)
                            for (int c = 0; c < C; c++)
                                grp[r][c] = req_i[r][c];
                        ph = PH_PICK;
                    end
                end
                PH_PICK: begin
                    if (!enable_i) begin
                        ph = PH_IDLE;
                        clear_srv();
                    end else begin
                        for (int k = 1; k <= R; k++) begin
                            rr = (m_ptr + k) % R;
                            if (sel < 0 && low_col(rr) >= 0) sel = rr;
                        end
                        if (sel >= 0) begin
                            m_ptr = sel;
                            m_x   = sel;
                            m_y   = low_col(sel);
                            ph    = PH_SHOW;
                        end else begin
                            ph = PH_DONE;
                        end
                    end
                end
                PH_SHOW: begin
                    if (!enable_i) begin
                        ph = PH_IDLE;
                        clear_srv();
                    end else if (ack_i || !m_pend(m_x, m_y)) begin
                        srv[m_x][m_y] = 1'b1;
                        if (low_col(m_x) >= 0) m_y = low_col(m_x);
                        else                   ph  = PH_PICK;
                    end
                end
                default: begin
                    clear_srv();
                    ph = PH_IDLE;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [R-1:0][C-1:0] exp_g;
        forever begin
            @(negedge clk);
            #1;
            exp_g = '0;
            if (ph == PH_SHOW) exp_g[m_x][m_y] = 1'b1;
            check("gnt_valid", gnt_valid_o, ph == PH_SHOW);
            check("gnt", gnt_o, exp_g);
            check("active", active_o, ph != PH_IDLE);
            check("grp_release", grp_release_o, ph == PH_DONE);
            check("req_o", req_o, |req_i);
            if (ph == PH_SHOW) begin
                check("x_add", x_add_o, m_x);
                check("y_add", y_add_o, m_y);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset_i  = 1'b1;
        enable_i = 1'b0;
        ack_i    = 1'b0;
        req_i    = '0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        gx.delete(); gy.delete(); gc.delete(); rc.delete();
        cyc = 0;
    endtask

    // One clock: log handshakes/releases visible now, advance, then the
    // served pixel withdraws its request.
    task automatic cycle();
        bit acc;
        int ax;
        int ay;
        acc = gnt_valid_o && ack_i;
        ax  = int'(x_add_o);
        ay  = int'(y_add_o);
        if (acc) begin
            gx.push_back(ax); gy.push_back(ay); gc.push_back(cyc);
        end
        if (grp_release_o) rc.push_back(cyc);
        @(negedge clk);
        cyc++;
        if (acc) req_i[ax][ay] = 1'b0;
    endtask

    task automatic check_grant(input int i, input int x, input int y, input int c);
        if (i < gx.size()) begin
            check($sformatf("grant%0d_x", i), gx[i], x);
            check($sformatf("grant%0d_y", i), gy[i], y);
            check($sformatf("grant%0d_cycle", i), gc[i], c);
        end else begin
            check($sformatf("grant%0d_present", i), gx.size(), i + 1);
        end
    endtask

    task automatic check_rel(input int i, input int c);
        if (i < rc.size()) check($sformatf("release%0d_cycle", i), rc[i], c);
        else               check($sformatf("release%0d_present", i), rc.size(), i + 1);
    endtask

    task automatic set_rows01();
        req_i    = '0;
        req_i[0] = 2'b11;
        req_i[1] = 2'b11;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        reset_i  = 1'b1;
        enable_i = 1'b0;
        ack_i    = 1'b0;
        req_i    = '0;
        @(negedge clk);
        do_reset();
        check("rst_gnt", gnt_o, 0);
        check("rst_valid", gnt_valid_o, 0);
        check("rst_x", x_add_o, 0);
        check("rst_y", y_add_o, 0);
        check("rst_active", active_o, 0);
        check("rst_release", grp_release_o, 0);

        // Full 2x2 group with ack held high.
        do_reset();
        set_rows01(); enable_i = 1'b1; ack_i = 1'b1;
        repeat (10) cycle();
        check_grant(0, 0, 0, 2);
        check_grant(1, 0, 1, 3);
        check_grant(2, 1, 0, 5);
        check_grant(3, 1, 1, 6);
        check_rel(0, 8);

        // Ack stall on grant (0,1).
        do_reset();
        set_rows01(); enable_i = 1'b1;
        for (int k = 0; k < 13; k++) begin
            ack_i = !(k >= 3 && k <= 5);
            if (k >= 3 && k <= 5) begin
                check("stall_valid", gnt_valid_o, 1);
                check("stall_x", x_add_o, 0);
                check("stall_y", y_add_o, 1);
                check("stall_gnt", gnt_o, 8'b0000_0010);
            end
            cycle();
        end
        check_grant(0, 0, 0, 2);
        check_grant(1, 0, 1, 6);
        check_grant(2, 1, 0, 8);
        check_grant(3, 1, 1, 9);
        check_rel(0, 11);

        // Late request (0,0) raised while (1,1) is granted.
        do_reset();
        req_i[1][1] = 1'b1; enable_i = 1'b1; ack_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) begin
                req_i[0][0] = 1'b1;
                ack_i       = 1'b1;
            end
            cycle();
        end
        check_grant(0, 1, 1, 2);
`ifdef PIXEL_LVL_SNAPSHOT_EN
        check_rel(0, 4);
        check_grant(1, 0, 0, 7);
`else
        check_grant(1, 0, 0, 4);
        check_rel(0, 6);
`endif

        // Row round-robin across groups, column 0 only.
        do_reset();
        req_i[2][0] = 1'b1; enable_i = 1'b1; ack_i = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 6) begin
                req_i[1][0] = 1'b1;
                req_i[3][0] = 1'b1;
            end
            cycle();
        end
        check_grant(0, 2, 0, 2);
        check_grant(1, 3, 0, 8);
        check_grant(2, 1, 0, 10);
        check_rel(0, 4);
        check_rel(1, 12);

        // Enable dropped during COL_GRANT, then re-enabled.
        do_reset();
        set_rows01(); enable_i = 1'b1; ack_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == 2) enable_i = 1'b0;
            if (k == 3) begin
                check("drop_valid", gnt_valid_o, 0);
                check("drop_gnt", gnt_o, 0);
                check("drop_active", active_o, 0);
                check("drop_release", grp_release_o, 0);
            end
            if (k == 5) begin
                enable_i = 1'b1;
                ack_i    = 1'b1;
            end
            cycle();
        end
        check_grant(0, 1, 0, 7);
        check_grant(1, 1, 1, 8);
        check_grant(2, 0, 0, 10);
        check_grant(3, 0, 1, 11);
        check("drop_release_count", rc.size(), 1);
        check_rel(0, 13);

        // Reset asserted mid-grant on (1,0).
        do_reset();
        set_rows01(); enable_i = 1'b1; ack_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) begin
                check("pre_rst_x", x_add_o, 1);
                reset_i = 1'b1;
            end
            if (k == 6) begin
                check("mid_rst_gnt", gnt_o, 0);
                check("mid_rst_valid", gnt_valid_o, 0);
                check("mid_rst_x", x_add_o, 0);
                check("mid_rst_y", y_add_o, 0);
                check("mid_rst_active", active_o, 0);
                check("mid_rst_release", grp_release_o, 0);
                reset_i = 1'b0;
                enable_i = 1'b0;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pixel_level_arb.md
# pixel_level_arb

Parametrised, single-clock successor to the primary-level pixel arbiter for the event-based pixel hierarchy. It serves a Lvl_ROWS x Lvl_COLS request array row-first, then column, using round-robin selection, and emits one grant at a time under a valid/ack handshake. When every request in the current group has been served, it pulses a group release. It sits between a pixel block (or lower level) and the next hierarchy level, and needs no derived or gated clocks.

## Interface
- Lvl_ROWS, 4, rows in the request array (>=2)
- Lvl_COLS, 4, columns in the request array (>=2)
- Lvl_ROW_ADD, $clog2(Lvl_ROWS), row address width
- Lvl_COL_ADD, $clog2(Lvl_COLS), column address width
- clk_i  input  1  sole clock; all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- enable_i  input  1  level enable from higher level
- req_i  input  [Lvl_ROWS-1:0][Lvl_COLS-1:0]  request array
- ack_i  input  1  consumer accepts the current grant
- gnt_o  output  [Lvl_ROWS-1:0][Lvl_COLS-1:0]  one-hot grant, zero when not valid
- gnt_valid_o  output  1  a grant is presented
- x_add_o  output  Lvl_ROW_ADD  granted row index
- y_add_o  output  Lvl_COL_ADD  granted column index
- active_o  output  1  FSM not in IDLE
- req_o  output  1  combinational |req_i
- grp_release_o  output  1  one-cycle pulse: group fully served

## Operation
- **Reset values:** state IDLE; gnt_o, gnt_valid_o, x_add_o, y_add_o, active_o and grp_release_o are all 0; served mask 0; row pointer Lvl_ROWS-1, so the first search starts at row 0.
- **Pending set:** pending = group requests & ~served.
- **IDLE:**
  - If enable_i and |req_i, go to ROW_SEL; with snapshot enabled, capture req_i into the group mask here.
  - Otherwise stay in IDLE.
- **ROW_SEL (1 cycle):**
  - Pick the first row with a pending bit, searching from (row pointer + 1) mod Lvl_ROWS with wrap.
  - Load x_add_o and the row pointer, then go to COL_GRANT.
  - If no row has a pending bit, go to RELEASE.
- **COL_GRANT:**
  - Present the lowest pending column of the selected row: gnt_valid_o=1, gnt_o bit set, y_add_o valid.
  - Hold all grant outputs stable until ack_i.
  - On ack_i, set the served bit. If another column in the row is pending, present it on the next cycle (no bubble). Otherwise go to ROW_SEL.
  - If the pending bit of the selected row vanishes before ack_i (possible only without snapshot), treat it as served and continue.
- **RELEASE:** grp_release_o=1 for exactly one cycle, clear the served mask, go to IDLE.
- **enable_i low in any non-IDLE state:**
  - Go to IDLE on the next edge; gnt_valid_o and gnt_o drop on that edge.
  - The served mask is cleared and no release pulse is issued.
  - The row pointer is retained.
- **Simultaneous events:**
  - ack_i and enable_i falling in the same cycle: the ack is honoured (served bit set), then the block goes to IDLE.
  - ack_i without gnt_valid_o is ignored.
- reset_i has priority over all events, including mid-grant.

## Timing
- Cycle 0: enable_i=1 and req_i!=0 sampled. Cycle 1: ROW_SEL. Cycle 2: first gnt_valid_o.
- Consecutive grants in the same row are 1 cycle apart when ack_i is held high.
- A row change inserts 1 bubble cycle (ROW_SEL).
- grp_release_o is asserted 2 cycles after the final ack (ROW_SEL, then RELEASE).
- active_o is registered and is 1 in ROW_SEL, COL_GRANT and RELEASE.

## Configuration
- **PIXEL_LVL_SNAPSHOT_EN defined:**
  - The group mask is captured from req_i when leaving IDLE.
  - Requests arriving mid-group wait for the next group.
- **PIXEL_LVL_SNAPSHOT_EN undefined:**
  - The group mask is live req_i.
  - New requests in unserved positions join the current group.
  - The group ends when req_i & ~served == 0.

## Structure
- lib_arbiter_pkg holds the pixel_lvl_state_t enum (IDLE, ROW_SEL, COL_GRANT, RELEASE) and the default row/column constants.
- One sub-module, rr_picker:
  - Parametrised width, combinational.
  - Returns the first set bit at or after a start index, with wrap, plus a found flag.
  - Instantiated once for rows and once for columns; the column instance uses start index 0.

## Test plan
- **Reset:** assert reset_i mid-grant with 2x2 req=4'b1111 → next cycle all outputs 0, state IDLE.
- **Full 2x2 group:** 2x2, req=4'b1111, enable=1, ack=1 → grants (0,0),(0,1) [bubble] (1,0),(1,1), then grp_release_o pulse 2 cycles after last ack.
- **Ack stall:** ack_i held low 3 cycles on grant (0,1) → gnt_o, x_add_o, y_add_o stable; next grant the cycle after ack.
- **Snapshot vs live:** 2x2, only (1,1) at start, (0,0) raised during grant of (1,1):
  - EN → release, then new group grants (0,0).
  - Not EN → (0,0) granted before the release.
- **Row round-robin:** 4x1, group 1 req rows {2}; group 2 req rows {1,3} → group 2 grants row 3 first, then row 1.
- **Enable drop:** enable_i dropped during COL_GRANT → gnt_valid_o=0 next cycle, no grp_release_o; re-enable restarts the group from ROW_SEL.
